// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial unsigned A - B - Bin using one reused adder slice
//            (A + ~B + ~Bin), LSB first.
// Revision : 1.0  initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_A,
  input  logic [WIDTH-1:0] io_B,
  input  logic             io_Bin,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_Diff,
  output logic             io_Bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_r;
  logic             carry;
  logic             bout_r;

  logic             accept;
  logic             last;
  logic             sum;
  logic             carry_next;
  logic [WIDTH:0]   diff_ext;

  assign accept   = io_in_valid && (state == IDLE);
  assign last     = (cnt == CW'(WIDTH - 1));
  assign diff_ext = {sum, diff_r};

  // Full-adder slice on a_i, ~b_i and the running carry
  always_comb begin
    sum        = a_sh[0] ^ ~b_sh[0] ^ carry;
    carry_next = (a_sh[0] & ~b_sh[0]) | (a_sh[0] & carry) | (~b_sh[0] & carry);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (io_in_valid) state_next = RUN;
      RUN:     if (last)        state_next = DONE;
      DONE:    if (io_out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Operands shift right so the slice always sees the current bit at [0]
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      diff_r <= '0;
      carry  <= 1'b0;
      bout_r <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      a_sh   <= io_A;
      b_sh   <= io_B;
      carry  <= ~io_Bin;
    end else if (state == RUN) begin
      cnt    <= cnt + 1'b1;
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      diff_r <= diff_ext[WIDTH:1];
      carry  <= carry_next;
      if (last) bout_r <= ~carry_next;
    end
  end

  assign io_in_ready  = (state == IDLE);
  assign io_out_valid = (state == DONE);
  assign io_Diff      = diff_r;
  assign io_Bout      = bout_r;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// Self-checking bench for serial_subtractor (WIDTH=4) against an arithmetic
// model of A - B - Bin, with directed cases and a full sweep under stalls.
module tb_serial_subtractor;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout;

  int chk_cnt = 0;
  int err_cnt = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .io_in_valid (in_valid),
    .io_in_ready (in_ready),
    .io_A        (a),
    .io_B        (b),
    .io_Bin      (bin),
    .io_out_valid(out_valid),
    .io_out_ready(out_ready),
    .io_Diff     (diff),
    .io_Bout     (bout)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_diff(input int x, input int y, input int z);
    return (x - y - z) & MASK;
  endfunction

  function automatic int model_bout(input int x, input int y, input int z);
    return (x < y + z) ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int x, input int y, input int z);
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_wait", int'(in_ready), 1);
    a = W'(x); b = W'(y); bin = z[0]; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
  endtask

  task automatic wait_out();
    int lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 20);
    check("latency", lat, W);
  endtask

  task automatic drain(input int x, input int y, input int z, input int stall);
    int ed = model_diff(x, y, z);
    int eb = model_bout(x, y, z);
    check("diff", int'(diff), ed);
    check("bout", int'(bout), eb);
    for (int k = 0; k < stall; k++) begin
      tick();
      check("stall_valid", int'(out_valid), 1);
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_diff", int'(diff), ed);
      check("stall_bout", int'(bout), eb);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_valid", int'(out_valid), 0);
    check("post_in_ready", int'(in_ready), 1);
  endtask

  task automatic op(input int x, input int y, input int z, input int stall);
    send(x, y, z);
    wait_out();
    drain(x, y, z, stall);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #23 reset = 1'b1;
    tick();

    // Basic op with out_ready held high
    out_ready = 1'b1;
    send(9, 3, 0);
    wait_out();
    drain(9, 3, 0, 0);

    // Asynchronous reset while idle clears the last result
    #2 reset = 1'b0;
    #1;
    check("rst_valid", int'(out_valid), 0);
    check("rst_diff", int'(diff), 0);
    check("rst_bout", int'(bout), 0);
    check("rst_in_ready", int'(in_ready), 1);
    #3 reset = 1'b1;
    tick();

    op(3, 9, 0, 0);
    op(0, 0, 1, 1);
    op(5, 5, 0, 0);
    op(0, 15, 1, 0);

    // Backpressure with a competing input request
    send(9, 4, 1);
    wait_out();
    in_valid = 1'b1; a = 4'd1; b = 4'd1; bin = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_diff", int'(diff), model_diff(9, 4, 1));
      check("bp_bout", int'(bout), model_bout(9, 4, 1));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_valid", int'(out_valid), 0);
    check("bp_release_ready", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("bp_accepted", int'(in_ready), 0);
    wait_out();
    drain(1, 1, 0, 0);

    // Reset during the third RUN cycle aborts the operation
    send(12, 7, 0);
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_valid", int'(out_valid), 0);
    check("abort_diff", int'(diff), 0);
    #2 reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("abort_no_valid", int'(out_valid), 0);
    end
    op(12, 7, 0, 0);

    // Full sweep, back-to-back with random stalls
    for (int i = 0; i < 512; i++) begin
      op((i >> 5) & 15, (i >> 1) & 15, i & 1, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
